mmio_auto_cpl_gen: RTL and testbench
====================================

// Module: mmio_auto_cpl_gen
// PURPOSE
//  Downstream of mmio_handler on the port TX path. Forwards AFU TX packets to the host and
//  feeds each forwarded completion's tag back so pending MMIO reads are cleared. When
//  mmio_handler presents a timed-out or flushed read, this block injects a synthetic CplD
//  (all-ones payload) at a packet boundary. It then acks mmio_handler. While traffic is
//  blocked, it discards AFU packets.
// PARAMETERS
//  TDATA_WIDTH  512  AXI-S data width; must be >= 320
//  CPL_STATUS   3'b000  completion status in synthetic CplD (SC)
// PORTS
//  clk                    in   1    clock
//  rst_n                  in   1    reset, synchronous, active-low
//  i_completer_id         in   16   completer ID field for synthetic CplD
//  i_blocking_traffic     in   1    port in error/flush; drop AFU packets
//  i_next_pending_mmio_rdy in  1    mmio_handler has a pending read to auto-complete
//  i_mmio_timeout_info    in   t_mmio_timeout_hdr_info  tag, dw0_len, req_id, addr of that read
//  o_mmio_rd_rsp_ack      out  1    1-cycle pulse: synthetic CplD accepted downstream
//  i_afu_tvalid/tlast     in   1    AFU TX stream (post protocol-check FIFO)
//  i_afu_tdata            in   TDATA_WIDTH  AFU beat; hdr DW0-2 in [95:0] on SOP
//  o_afu_tready           out  1    AFU stream ready
//  o_tx_tvalid/tlast      out  1    stream to PCIe SS
//  o_tx_tdata             out  TDATA_WIDTH
//  i_tx_tready            in   1
//  o_fwd_cpl_sop          out  1    forwarded AFU Cpl/CplD SOP handshaked (-> i_tx_f_fifo_valid_sop_cmpl)
//  o_fwd_cpl_tag          out  PCIE_TLP_TAG_WIDTH  its tag
// BEHAVIOUR
//  Reset: all outputs 0; FSM=PASS; in_pkt=0; drop_pkt=0; captured info=0.
//  Output handshake: o_tx_tvalid held with stable data until i_tx_tready. Output register is a
//   1-deep skid; latency in->out = 1 cycle. No bubbles on back-to-back beats when tready=1.
//  in_pkt: set on accepted non-tlast beat; cleared on accepted tlast beat.
//  FSM:
//   PASS: o_afu_tready = skid space. If !in_pkt && i_next_pending_mmio_rdy -> capture info, go to
//    INJECT; AFU is stalled that cycle. If in_pkt && rdy -> go to WAIT_EOP.
//   WAIT_EOP: forward AFU until the tlast beat is accepted, then capture info and go to INJECT.
//   INJECT: drive 1-beat CplD, tlast=1. AFU is stalled. On tx handshake pulse
//    o_mmio_rd_rsp_ack and go to ACK_GAP.
//   ACK_GAP: 1 cycle, ignore rdy (handler drops it next cycle) -> PASS.
//  CplD format: DW0 fmt=3'b010, type=5'b01010, TC/attr=0, length=dw0_len. DW1={completer_id,
//   CPL_STATUS, BCM=0, byte_count=dw0_len*4 (12b)}. DW2={req_id, tag, 1'b0, addr[6:2],2'b00}.
//   DW3..7 = 0. Payload DWs at [287:256] and [319:288]: 32'hFFFF_FFFF if within dw0_len, else 0.
//   Remaining bits are 0.
//  Blocking: if i_blocking_traffic is seen at an AFU SOP, the whole packet is dropped
//   (tready=1, not forwarded, no o_fwd_cpl_sop). A packet already in flight is forwarded to tlast.
//   Injection is unaffected by blocking.
//  o_fwd_cpl_sop: registered, asserted the cycle after an accepted forwarded SOP beat whose
//   fmt/type is Cpl (3'b000/01010) or CplD (3'b010/01010); tag = DW2[15:8] (widened per pkg width).
//  Simultaneous: rdy and AFU SOP in the same PASS cycle -> injection wins, AFU SOP waits.
//  tready low during INJECT: hold the beat and do not ack; the info register is stable.
//  Reset mid-packet: in_pkt and skid cleared; downstream must tolerate truncation (reset is global).
// STRUCTURE
//  prtcl_chkr_pkg: t_mmio_timeout_hdr_info (existing), plus new constants CPLD_FMT, CPL_FMT,
//   CPL_TYPE, and function f_build_auto_cpld(info, cid, status) returning the TDATA beat.
//  Sub-module: axis_skid_reg (1-deep registered slice) for the output stage.
//  FSM, in_pkt/drop tracking and completion decode live in this module.
// TESTING
//  1. Idle AFU; rdy=1, info{tag=5,len=1,req=0x0100,addr=0x1004}, tready=1 -> one CplD beat:
//     len=1, byte_count=4, lower addr=0x04, DW8=FFFF_FFFF, DW9=0; ack pulses exactly once.
//  2. rdy asserted mid 4-beat AFU packet -> all 4 beats forwarded contiguously, then CplD
//     (len=2, DW8 and DW9 both all-ones).
//  3. Inject while tready=0 for 5 cycles -> tdata stable; ack only in the cycle after tready=1.
//  4. AFU CplD with tag 0x2A forwarded -> o_fwd_cpl_sop=1 for one cycle, tag=0x2A; an AFU MWr
//     produces no pulse.
//  5. blocking=1 before SOP of a 3-beat packet -> no tx beats, tready=1 throughout; blocking
//     raised on beat 2 -> that packet is completed, the next packet is dropped.
//  6. Assert rst_n=0 during INJECT -> all outputs 0 next cycle; FSM=PASS; no ack.

Source files
------------

// File: rtl/mmio_auto_cpl_gen_pkg.sv
// Shared types and helpers for the TX-path MMIO auto-completion generator.
// Covers the timeout info record, TLP fmt/type constants and the synthetic CplD builder.
package mmio_auto_cpl_gen_pkg;

   localparam int PCIE_TLP_TAG_WIDTH = 10;
   localparam int AUTO_CPLD_W        = 320;

   localparam logic [2:0] CPLD_FMT = 3'b010;
   localparam logic [2:0] CPL_FMT  = 3'b000;
   localparam logic [4:0] CPL_TYPE = 5'b01010;

   typedef struct packed {
      logic [PCIE_TLP_TAG_WIDTH-1:0] tag;
      logic [9:0]                    dw0_len;
      logic [15:0]                   req_id;
      logic [63:0]                   addr;
   } t_mmio_timeout_hdr_info;

   typedef enum logic [1:0] {
      ST_PASS,
      ST_WAIT_EOP,
      ST_INJECT,
      ST_ACK_GAP
   } t_acg_state;

   function automatic logic f_is_cpl(input logic [31:0] dw0);
      return ((dw0[31:29] == CPL_FMT) || (dw0[31:29] == CPLD_FMT)) && (dw0[28:24] == CPL_TYPE);
   endfunction

   function automatic logic [AUTO_CPLD_W-1:0] f_build_auto_cpld(
      input t_mmio_timeout_hdr_info info,
      input logic [15:0]            cid,
      input logic [2:0]             status
   );
      logic [AUTO_CPLD_W-1:0] beat;
      beat          = '0;
      beat[31:29]   = CPLD_FMT;
      beat[28:24]   = CPL_TYPE;
      beat[9:0]     = info.dw0_len;
      beat[63:48]   = cid;
      beat[47:45]   = status;
      beat[44]      = 1'b0;
      beat[43:32]   = {info.dw0_len, 2'b00};
      beat[95:80]   = info.req_id;
      beat[79:72]   = info.tag[7:0];
      beat[71]      = 1'b0;
      beat[70:64]   = {info.addr[6:2], 2'b00};
      // A length of 0 encodes 1024 DW, so the first payload DW is always covered
      beat[287:256] = '1;
      if (info.dw0_len != 10'd1) beat[319:288] = '1;
      return beat;
   endfunction

endpackage

// File: rtl/mmio_auto_cpl_gen_if.sv
// AXI-Stream bundle used for both the AFU input and the PCIe SS output of the generator.
interface mmio_auto_cpl_gen_if #(parameter int TDATA_WIDTH = 512);
   logic                   tvalid;
   logic                   tready;
   logic                   tlast;
   logic [TDATA_WIDTH-1:0] tdata;

   modport master (output tvalid, output tlast, output tdata, input tready);
   modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/mmio_auto_cpl_gen_axis_skid_reg.sv
// One-deep registered AXI-S slice: 1-cycle latency, full throughput while the sink is ready.
module axis_skid_reg #(
   parameter int W = 512
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_valid,
   input  logic         s_last,
   input  logic [W-1:0] s_data,
   output logic         s_ready,
   output logic         m_valid,
   output logic         m_last,
   output logic [W-1:0] m_data,
   input  logic         m_ready
);
   logic         valid_q, valid_d;
   logic         last_q, last_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      s_ready = !valid_q || m_ready;
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      if (s_ready) begin
         valid_d = s_valid;
         if (s_valid) begin
            last_d = s_last;
            data_d = s_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign m_valid = valid_q;
   assign m_last  = last_q;
   assign m_data  = data_q;
endmodule

// File: rtl/mmio_auto_cpl_gen.sv
// Forwards AFU TX packets to the host and splices a synthetic all-ones CplD in at a packet
// boundary for each MMIO read that mmio_handler gives up on; drops AFU packets while blocked.
module mmio_auto_cpl_gen
   import mmio_auto_cpl_gen_pkg::*;
#(
   parameter int         TDATA_WIDTH = 512,
   parameter logic [2:0] CPL_STATUS  = 3'b000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [15:0]                   i_completer_id,
   input  logic                          i_blocking_traffic,
   input  logic                          i_next_pending_mmio_rdy,
   input  t_mmio_timeout_hdr_info        i_mmio_timeout_info,
   output logic                          o_mmio_rd_rsp_ack,
   mmio_auto_cpl_gen_if.slave            afu_if,
   mmio_auto_cpl_gen_if.master           tx_if,
   output logic                          o_fwd_cpl_sop,
   output logic [PCIE_TLP_TAG_WIDTH-1:0] o_fwd_cpl_tag
);
   t_acg_state                    state_q, state_d;
   t_mmio_timeout_hdr_info        info_q, info_d;
   logic                          in_pkt_q, in_pkt_d;
   logic                          drop_pkt_q, drop_pkt_d;
   logic                          inj_sent_q, inj_sent_d;
   logic                          ack_q, ack_d;
   logic                          fwd_sop_q, fwd_sop_d;
   logic [PCIE_TLP_TAG_WIDTH-1:0] fwd_tag_q, fwd_tag_d;

   logic                   sk_valid, sk_last, sk_ready;
   logic [TDATA_WIDTH-1:0] sk_data, cpld_beat;
   logic                   fwd_en, afu_sop, drop_now, afu_tready, afu_hs;

   always_comb begin
      cpld_beat = '0;
      cpld_beat[AUTO_CPLD_W-1:0] = f_build_auto_cpld(info_q, i_completer_id, CPL_STATUS);
   end

   always_comb begin
      afu_sop    = !in_pkt_q;
      // Drop decision is latched at SOP so blocking never truncates a packet in flight
      drop_now   = afu_sop ? i_blocking_traffic : drop_pkt_q;
      state_d    = state_q;
      info_d     = info_q;
      inj_sent_d = inj_sent_q;
      ack_d      = 1'b0;
      fwd_en     = 1'b0;
      sk_valid   = 1'b0;
      sk_last    = 1'b0;
      sk_data    = afu_if.tdata;

      case (state_q)
         ST_PASS: begin
            if (!in_pkt_q && i_next_pending_mmio_rdy) begin
               info_d  = i_mmio_timeout_info;
               state_d = ST_INJECT;
            end else begin
               fwd_en = 1'b1;
               if (in_pkt_q && i_next_pending_mmio_rdy) state_d = ST_WAIT_EOP;
            end
         end
         ST_WAIT_EOP: fwd_en = 1'b1;
         ST_INJECT: begin
            sk_valid = !inj_sent_q;
            sk_last  = 1'b1;
            sk_data  = cpld_beat;
            if (!inj_sent_q && sk_ready) inj_sent_d = 1'b1;
            // Once loaded, the slice holds only the CplD, so its output handshake is the ack point
            if (inj_sent_q && tx_if.tvalid && tx_if.tready) begin
               ack_d      = 1'b1;
               inj_sent_d = 1'b0;
               state_d    = ST_ACK_GAP;
            end
         end
         ST_ACK_GAP: state_d = ST_PASS;
         default:    state_d = ST_PASS;
      endcase

      afu_tready = fwd_en && (drop_now || sk_ready);
      afu_hs     = afu_if.tvalid && afu_tready;
      if (fwd_en) begin
         sk_valid = afu_if.tvalid && !drop_now;
         sk_last  = afu_if.tlast;
      end

      if (afu_hs && afu_if.tlast &&
          ((state_q == ST_WAIT_EOP) || ((state_q == ST_PASS) && in_pkt_q && i_next_pending_mmio_rdy))) begin
         info_d  = i_mmio_timeout_info;
         state_d = ST_INJECT;
      end

      in_pkt_d   = afu_hs ? !afu_if.tlast : in_pkt_q;
      drop_pkt_d = afu_hs ? (drop_now && !afu_if.tlast) : drop_pkt_q;

      fwd_sop_d = afu_hs && afu_sop && !drop_now && f_is_cpl(afu_if.tdata[31:0]);
      fwd_tag_d = fwd_tag_q;
      if (fwd_sop_d) begin
         fwd_tag_d      = '0;
         fwd_tag_d[7:0] = afu_if.tdata[79:72];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_PASS;
         info_q     <= '0;
         in_pkt_q   <= 1'b0;
         drop_pkt_q <= 1'b0;
         inj_sent_q <= 1'b0;
         ack_q      <= 1'b0;
         fwd_sop_q  <= 1'b0;
         fwd_tag_q  <= '0;
      end else begin
         state_q    <= state_d;
         info_q     <= info_d;
         in_pkt_q   <= in_pkt_d;
         drop_pkt_q <= drop_pkt_d;
         inj_sent_q <= inj_sent_d;
         ack_q      <= ack_d;
         fwd_sop_q  <= fwd_sop_d;
         fwd_tag_q  <= fwd_tag_d;
      end
   end

   axis_skid_reg #(.W(TDATA_WIDTH)) u_out_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (sk_valid),
      .s_last  (sk_last),
      .s_data  (sk_data),
      .s_ready (sk_ready),
      .m_valid (tx_if.tvalid),
      .m_last  (tx_if.tlast),
      .m_data  (tx_if.tdata),
      .m_ready (tx_if.tready)
   );

   assign afu_if.tready     = afu_tready && rst_n;
   assign o_mmio_rd_rsp_ack = ack_q;
   assign o_fwd_cpl_sop     = fwd_sop_q;
   assign o_fwd_cpl_tag     = fwd_tag_q;
endmodule

// File: tb/tb_mmio_auto_cpl_gen.sv
// Directed bench for mmio_auto_cpl_gen: injection, packet-boundary wait, backpressure,
// completion tag feedback, blocking drop and reset during injection.
module tb_mmio_auto_cpl_gen;
   import mmio_auto_cpl_gen_pkg::*;

   localparam int W = 512;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic [15:0]                   cid;
   logic                          blocking, rdy;
   t_mmio_timeout_hdr_info        info;
   logic                          ack, fwd_sop;
   logic [PCIE_TLP_TAG_WIDTH-1:0] fwd_tag;

   mmio_auto_cpl_gen_if #(.TDATA_WIDTH(W)) afu_bus ();
   mmio_auto_cpl_gen_if #(.TDATA_WIDTH(W)) tx_bus ();

   mmio_auto_cpl_gen #(.TDATA_WIDTH(W), .CPL_STATUS(3'b000)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .i_completer_id          (cid),
      .i_blocking_traffic      (blocking),
      .i_next_pending_mmio_rdy (rdy),
      .i_mmio_timeout_info     (info),
      .o_mmio_rd_rsp_ack       (ack),
      .afu_if                  (afu_bus),
      .tx_if                   (tx_bus),
      .o_fwd_cpl_sop           (fwd_sop),
      .o_fwd_cpl_tag           (fwd_tag)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, cyc = 0, ack_cnt = 0;
   bit afu_acc;
   logic [W-1:0] tx_log[$];
   int           tx_cyc[$];
   int           fwd_log[$];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called at a negedge after inputs are set; observes the upcoming posedge transfer.
   task automatic step();
      #1;
      afu_acc = afu_bus.tvalid && afu_bus.tready;
      if (tx_bus.tvalid && tx_bus.tready) begin
         tx_log.push_back(tx_bus.tdata);
         tx_cyc.push_back(cyc);
      end
      if (ack) begin
         ack_cnt++;
         rdy = 1'b0;
      end
      if (fwd_sop) fwd_log.push_back(int'(fwd_tag));
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [W-1:0] d, input logic last);
      afu_bus.tvalid = 1'b1;
      afu_bus.tdata  = d;
      afu_bus.tlast  = last;
      for (int k = 0; k < 20; k++) begin
         step();
         if (afu_acc) break;
      end
      chk("afu_accept", afu_acc, 1);
      afu_bus.tvalid = 1'b0;
      afu_bus.tlast  = 1'b0;
   endtask

   task automatic wait_tx(input string tag, input int budget);
      for (int k = 0; k < budget && !tx_bus.tvalid; k++) step();
      chk(tag, tx_bus.tvalid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] pkt[4];
      logic [W-1:0] pa[3];
      logic [W-1:0] pb[3];
      logic [W-1:0] b, hold;
      int c0;

      afu_bus.tvalid = 1'b0;
      afu_bus.tlast  = 1'b0;
      afu_bus.tdata  = '0;
      tx_bus.tready  = 1'b1;
      rdy      = 1'b0;
      blocking = 1'b0;
      info     = '0;
      cid      = 16'h0200;
      rst_n    = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_tvalid", tx_bus.tvalid, 0);
      chk("rst_tlast", tx_bus.tlast, 0);
      chk("rst_tdata", tx_bus.tdata, 0);
      chk("rst_ack", ack, 0);
      chk("rst_fwd_sop", fwd_sop, 0);
      chk("rst_fwd_tag", fwd_tag, 0);
      chk("rst_afu_tready", afu_bus.tready, 0);
      rst_n = 1'b1;
      idle(2);

      // 1: idle AFU, single injection
      tx_log.delete(); tx_cyc.delete(); ack_cnt = 0;
      info = '{tag: 10'd5, dw0_len: 10'd1, req_id: 16'h0100, addr: 64'h1004};
      rdy  = 1'b1;
      wait_tx("t1_valid", 10);
      b = tx_bus.tdata;
      chk("t1_dw0", b[31:0], 32'h4A00_0001);
      chk("t1_dw1", b[63:32], 32'h0200_0004);
      chk("t1_dw2", b[95:64], 32'h0100_0504);
      chk("t1_dw3_7", b[255:96], 0);
      chk("t1_dw8", b[287:256], 32'hFFFF_FFFF);
      chk("t1_dw9", b[319:288], 0);
      chk("t1_upper", b[511:320], 0);
      chk("t1_tlast", tx_bus.tlast, 1);
      idle(6);
      chk("t1_ack_once", ack_cnt, 1);
      chk("t1_beats", tx_log.size(), 1);

      // 2: rdy mid 4-beat packet waits for EOP
      tx_log.delete(); tx_cyc.delete(); ack_cnt = 0;
      for (int i = 0; i < 4; i++) pkt[i] = {16{32'hC0DE_0000 + i}};
      pkt[0][31:0] = 32'h6000_0004;
      send(pkt[0], 1'b0);
      info = '{tag: 10'd7, dw0_len: 10'd2, req_id: 16'h0300, addr: 64'h2008};
      rdy  = 1'b1;
      send(pkt[1], 1'b0);
      send(pkt[2], 1'b0);
      send(pkt[3], 1'b1);
      for (int k = 0; k < 20 && ack_cnt == 0; k++) step();
      idle(2);
      chk("t2_nbeats", tx_log.size(), 5);
      if (tx_log.size() == 5) begin
         for (int i = 0; i < 4; i++) chk($sformatf("t2_beat%0d", i), tx_log[i], pkt[i]);
         chk("t2_contig", tx_cyc[3] - tx_cyc[0], 3);
         b = tx_log[4];
         chk("t2_dw0", b[31:0], 32'h4A00_0002);
         chk("t2_dw1", b[63:32], 32'h0200_0008);
         chk("t2_dw2", b[95:64], 32'h0300_0708);
         chk("t2_dw8", b[287:256], 32'hFFFF_FFFF);
         chk("t2_dw9", b[319:288], 32'hFFFF_FFFF);
      end
      chk("t2_ack", ack_cnt, 1);

      // 3: injection under backpressure
      tx_log.delete(); ack_cnt = 0;
      tx_bus.tready = 1'b0;
      info = '{tag: 10'd9, dw0_len: 10'd1, req_id: 16'h0400, addr: 64'h3010};
      rdy  = 1'b1;
      wait_tx("t3_valid", 10);
      hold = tx_bus.tdata;
      chk("t3_dw2", hold[95:64], 32'h0400_0910);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_hold", tx_bus.tdata, hold);
         chk("t3_valid_hold", tx_bus.tvalid, 1);
      end
      chk("t3_no_ack", ack_cnt, 0);
      tx_bus.tready = 1'b1;
      step();
      chk("t3_ack_pending", ack_cnt, 0);
      step();
      chk("t3_ack", ack_cnt, 1);
      idle(2);

      // 4: completion tag feedback
      tx_log.delete(); fwd_log.delete();
      b = '0;
      b[31:0]    = 32'h4A00_0001;
      b[63:32]   = 32'h0123_0004;
      b[95:64]   = {16'h0200, 8'h2A, 8'h00};
      b[287:256] = 32'hDEAD_BEEF;
      send(b, 1'b1);
      idle(3);
      chk("t4_fwd_cnt", fwd_log.size(), 1);
      if (fwd_log.size() == 1) chk("t4_fwd_tag", fwd_log[0], 32'h2A);
      fwd_log.delete();
      b[31:0] = 32'h4000_0001;
      send(b, 1'b1);
      idle(3);
      chk("t4_mwr_no_fwd", fwd_log.size(), 0);
      chk("t4_beats", tx_log.size(), 2);

      // 5: blocking drop
      tx_log.delete(); fwd_log.delete();
      for (int i = 0; i < 3; i++) begin
         pa[i] = {16{32'hAAAA_0000 + i}};
         pb[i] = {16{32'hBBBB_0000 + i}};
      end
      pa[0][95:0] = {16'h0200, 8'h44, 8'h00, 32'h0123_0008, 32'h4A00_0002};
      pb[0][95:0] = {16'h0200, 8'h33, 8'h00, 32'h0123_0008, 32'h4A00_0002};
      blocking = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 3; i++) send(pb[i], i == 2);
      chk("t5_drop_rate", cyc - c0, 3);
      idle(3);
      chk("t5_dropped", tx_log.size(), 0);
      blocking = 1'b0;
      send(pa[0], 1'b0);
      blocking = 1'b1;
      send(pa[1], 1'b0);
      send(pa[2], 1'b1);
      for (int i = 0; i < 3; i++) send(pb[i], i == 2);
      idle(3);
      chk("t5_fwd_beats", tx_log.size(), 3);
      if (tx_log.size() == 3) begin
         chk("t5_beat0", tx_log[0], pa[0]);
         chk("t5_beat2", tx_log[2], pa[2]);
      end
      chk("t5_fwd_cnt", fwd_log.size(), 1);
      if (fwd_log.size() == 1) chk("t5_fwd_tag", fwd_log[0], 32'h44);
      blocking = 1'b0;

      // 6: reset during injection
      tx_log.delete(); ack_cnt = 0;
      tx_bus.tready = 1'b0;
      info = '{tag: 10'd3, dw0_len: 10'd1, req_id: 16'h0500, addr: 64'h4000};
      rdy  = 1'b1;
      wait_tx("t6_valid", 10);
      rst_n = 1'b0;
      step();
      chk("t6_tvalid", tx_bus.tvalid, 0);
      chk("t6_tlast", tx_bus.tlast, 0);
      chk("t6_tdata", tx_bus.tdata, 0);
      chk("t6_ack", ack, 0);
      chk("t6_fwd_sop", fwd_sop, 0);
      chk("t6_afu_tready", afu_bus.tready, 0);
      rdy   = 1'b0;
      rst_n = 1'b1;
      tx_bus.tready = 1'b1;
      idle(4);
      chk("t6_no_ack", ack_cnt, 0);
      chk("t6_no_tx", tx_log.size(), 0);
      b = '0;
      b[31:0] = 32'h4000_0001;
      c0 = cyc;
      send(b, 1'b1);
      chk("t6_pass_accept", cyc - c0, 1);
      idle(2);
      chk("t6_pass_fwd", tx_log.size(), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
